// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: merges the pipeline writeback port with a secondary
// (CP0/bus-bridge) register-file writer. The pipeline always wins the
// single write port. Secondary writes wait in a 2-entry FIFO and drain
// into idle writeback slots. A buffered head that is blocked for
// STARVE_LIMIT cycles raises stall_req so the pipeline inserts a bubble.
// Optional feature: define REGWRITE_ARB_SCOREBOARD_EN to drive pend_hit
// from the buffered addresses; otherwise pend_hit is tied low.
module regwrite_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteW,
    input  logic [4:0]  AwriteW,
    input  logic [31:0] ResultW,
    input  logic        sec_valid,
    input  logic [4:0]  sec_addr,
    input  logic [31:0] sec_data,
    output logic        sec_ready,
    output logic        RegWrite,
    output logic [4:0]  Awrite,
    output logic [31:0] WD,
    output logic        stall_req,
    input  logic [4:0]  pend_addr_a,
    input  logic [4:0]  pend_addr_b,
    output logic        pend_hit
);

    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    // Entries are kept compacted: slot 0 is always the head.
    entry_t [1:0] fifoQ, fifoD;
    logic [1:0]   cntQ, cntD;
    logic         readyQ;
    logic [3:0]   starveQ, starveD;
    logic         stallQ;

    logic   pipeActive, push, pop, headInv, keep0, keep1, blocked;
    entry_t newEntry;

    assign pipeActive = RegWriteW && (AwriteW != 5'd0);
    // Writes to $0 are accepted (handshake completes) but never buffered.
    assign push       = sec_valid && readyQ && (sec_addr != 5'd0);
    assign pop        = !pipeActive && (cntQ != 2'd0);
    // Pipeline data to the same register is newer, so the buffered copy dies.
    assign headInv    = pipeActive && (cntQ != 2'd0) && (fifoQ[0].addr == AwriteW);
    assign keep0      = (cntQ != 2'd0) && !pop && !headInv;
    assign keep1      = (cntQ == 2'd2) && !(pipeActive && (fifoQ[1].addr == AwriteW));
    assign blocked    = pipeActive && (cntQ != 2'd0) && !headInv;
    assign newEntry   = '{addr: sec_addr, data: sec_data};

    // Next FIFO contents: survivors in order, then the new push appended.
    always_comb begin
        fifoD = fifoQ;
        cntD  = 2'd0;
        if (keep0) begin
            fifoD[0] = fifoQ[0];
            cntD     = 2'd1;
        end
        if (keep1) begin
            if (cntD == 2'd0) fifoD[0] = fifoQ[1];
            else              fifoD[1] = fifoQ[1];
            cntD = cntD + 2'd1;
        end
        if (push) begin
            if (cntD == 2'd0) fifoD[0] = newEntry;
            else              fifoD[1] = newEntry;
            cntD = cntD + 2'd1;
        end
    end

    // Starvation counter saturates at the limit while the head stays blocked.
    always_comb begin
        starveD = 4'd0;
        if (blocked) starveD = (starveQ >= LIM) ? LIM : starveQ + 4'd1;
    end

    // State registers; reset drops every buffered entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifoQ   <= '0;
            cntQ    <= 2'd0;
            readyQ  <= 1'b0;
            starveQ <= 4'd0;
            stallQ  <= 1'b0;
        end else begin
            fifoQ   <= fifoD;
            cntQ    <= cntD;
            readyQ  <= (cntD != 2'd2);
            starveQ <= starveD;
            stallQ  <= (starveD == LIM);
        end
    end

    assign sec_ready = readyQ;
    assign stall_req = stallQ;

    // Write-port mux: pipeline first, then FIFO head, else idle.
    always_comb begin
        RegWrite = 1'b0;
        Awrite   = 5'd0;
        WD       = 32'd0;
        if (reset) begin
            if (pipeActive) begin
                RegWrite = 1'b1;
                Awrite   = AwriteW;
                WD       = ResultW;
            end else if (cntQ != 2'd0) begin
                RegWrite = 1'b1;
                Awrite   = fifoQ[0].addr;
                WD       = fifoQ[0].data;
            end
        end
    end

`ifdef REGWRITE_ARB_SCOREBOARD_EN
    logic hit0, hit1;
    assign hit0 = (cntQ != 2'd0) &&
                  ((fifoQ[0].addr == pend_addr_a) || (fifoQ[0].addr == pend_addr_b));
    assign hit1 = (cntQ == 2'd2) &&
                  ((fifoQ[1].addr == pend_addr_a) || (fifoQ[1].addr == pend_addr_b));
    // Hazard flag for the issue stage: a buffered write targets a source reg.
    always_comb begin
        pend_hit = reset && (hit0 || hit1);
    end
`else
    logic unusedPend;
    assign unusedPend = ^{pend_addr_a, pend_addr_b};
    assign pend_hit   = 1'b0;
`endif

endmodule
